// File: rtl/screen_fade_ctrl.sv
// Screen-change sequencer: fades the VGA colour path to black, swaps the rendered screen
// on a frame boundary, then fades back in. Fade steps advance on v_sync falling edges.
module screen_fade_ctrl #(
    parameter int unsigned NUM_SCREENS     = 4,
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned INIT_SCREEN     = 0,
    localparam int unsigned SW = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1
) (
    input  logic          clk_25,
    input  logic          reset,
    input  logic          v_sync,
    input  logic          req,
    input  logic [SW-1:0] req_screen,
    input  logic [3:0]    red_in,
    input  logic [3:0]    green_in,
    input  logic [3:0]    blue_in,
    output logic [3:0]    red_out,
    output logic [3:0]    green_out,
    output logic [3:0]    blue_out,
    output logic [SW-1:0] cur_screen,
    output logic          busy,
    output logic          ack
);

    localparam logic [7:0]    CNT_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [4:0]    LVL_FULL = 5'd16;
    localparam logic [SW-1:0] SCR_INIT = SW'(INIT_SCREEN);

    typedef enum logic [1:0] {StIdle, StFadeOut, StSwap, StFadeIn} state_e;

    state_e        state_q, state_d;
    logic [4:0]    level_q;
    logic [7:0]    cnt_q;
    logic [SW-1:0] target_q;
    logic          vs_d;
    logic          vs_mask_q;

    logic tick, step, req_ok, accept, same, fade_out_done, fade_in_done;

    // vs_mask_q suppresses the false edge implied by vs_d resetting high while v_sync is low
    assign tick          = vs_d & ~v_sync & ~vs_mask_q;
    assign step          = tick && (cnt_q == CNT_LAST);
    // A request in the ack cycle is dropped so a completion is never chained in the same cycle
    assign req_ok        = (state_q == StIdle) && req && !ack;
    assign accept        = req_ok && (req_screen != cur_screen);
    assign same          = req_ok && (req_screen == cur_screen);
    assign fade_out_done = (state_q == StFadeOut) && step && (level_q == 5'd1);
    assign fade_in_done  = (state_q == StFadeIn) && step && (level_q == 5'd15);

    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
        logic [8:0] p;
        p = {5'd0, c} * {4'd0, l};
        return 4'(p >> 4);
    endfunction

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept)        state_d = StFadeOut;
            StFadeOut: if (fade_out_done) state_d = StSwap;
            StSwap:    if (tick)          state_d = StFadeIn;
            StFadeIn:  if (fade_in_done)  state_d = StIdle;
            default:                      state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            level_q    <= LVL_FULL;
            cnt_q      <= 8'd0;
            target_q   <= SCR_INIT;
            cur_screen <= SCR_INIT;
            vs_d       <= 1'b1;
            vs_mask_q  <= 1'b1;
            ack        <= 1'b0;
            red_out    <= 4'd0;
            green_out  <= 4'd0;
            blue_out   <= 4'd0;
        end else begin
            vs_d      <= v_sync;
            vs_mask_q <= 1'b0;
            ack       <= same || fade_in_done;
            red_out   <= scale(red_in, level_q);
            green_out <= scale(green_in, level_q);
            blue_out  <= scale(blue_in, level_q);

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        target_q <= req_screen;
                        cnt_q    <= 8'd0;
                    end
                end
                StFadeOut: begin
                    if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= 8'd0;
                            if (level_q != 5'd0) level_q <= level_q - 5'd1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                StSwap: begin
                    if (tick) begin
                        cur_screen <= target_q;
                        cnt_q      <= 8'd0;
                    end
                end
                StFadeIn: begin
                    if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= 8'd0;
                            if (level_q != LVL_FULL) level_q <= level_q + 5'd1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_fade_ctrl.sv
// Bench for screen_fade_ctrl: directed literal checks plus randomized traffic compared
// every cycle against a tick-count model of the fade sequence.
module tb_screen_fade_ctrl;

    localparam int F    = 2;
    localparam int NS   = 4;
    localparam int INIT = 0;

    logic       clk_25 = 1'b0;
    logic       reset, v_sync, req;
    logic [1:0] req_screen;
    logic [3:0] red_in, green_in, blue_in;
    logic [3:0] red_out, green_out, blue_out;
    logic [1:0] cur_screen;
    logic       busy, ack;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    screen_fade_ctrl #(
        .NUM_SCREENS    (NS),
        .FRAMES_PER_STEP(F),
        .INIT_SCREEN    (INIT)
    ) dut (
        .clk_25    (clk_25),
        .reset     (reset),
        .v_sync    (v_sync),
        .req       (req),
        .req_screen(req_screen),
        .red_in    (red_in),
        .green_in  (green_in),
        .blue_in   (blue_in),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out),
        .cur_screen(cur_screen),
        .busy      (busy),
        .ack       (ack)
    );

    always #5 clk_25 = ~clk_25;

    // Model: a transition is just a count of ticks since acceptance; brightness is derived from it.
    bit m_busy, m_ack, m_vs, m_first, m_tk, m_old_ack;
    int m_n, m_tgt, m_cur, m_lvl;
    int e_r, e_g, e_b;

    function automatic int lvl_of(bit b, int n);
        if (!b) return 16;
        if (n <= 16 * F) return 16 - n / F;
        return (n - 16 * F - 1) / F;
    endfunction

    always @(posedge clk_25) begin
        if (reset) begin
            m_busy = 0; m_n = 0; m_tgt = INIT; m_cur = INIT; m_ack = 0;
            m_vs = 1; m_first = 1; e_r = 0; e_g = 0; e_b = 0;
        end else begin
            m_tk    = m_vs && !v_sync && !m_first;
            m_vs    = v_sync;
            m_first = 0;
            m_lvl   = lvl_of(m_busy, m_n);
            e_r = (int'(red_in) * m_lvl) / 16;
            e_g = (int'(green_in) * m_lvl) / 16;
            e_b = (int'(blue_in) * m_lvl) / 16;
            m_old_ack = m_ack;
            m_ack = 0;
            if (!m_busy) begin
                if (req && !m_old_ack) begin
                    if (int'(req_screen) != m_cur) begin
                        m_busy = 1; m_n = 0; m_tgt = int'(req_screen);
                    end else begin
                        m_ack = 1;
                    end
                end
            end else if (m_tk) begin
                m_n++;
                if (m_n == 16 * F + 1) m_cur = m_tgt;
                if (m_n == 32 * F + 1) begin
                    m_busy = 0; m_ack = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_25) begin
        if (started) begin
            chk("red", int'(red_out), e_r);
            chk("green", int'(green_out), e_g);
            chk("blue", int'(blue_out), e_b);
            chk("cur_screen", int'(cur_screen), m_cur);
            chk("busy", int'(busy), int'(m_busy));
            chk("ack", int'(ack), int'(m_ack));
        end
    end

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    // One frame: v_sync high for hi cycles, then a falling edge (the tick) and lo low cycles.
    task automatic frame(input int hi, input int lo);
        v_sync = 1'b1;
        repeat (hi) step();
        v_sync = 1'b0;
        repeat (lo) step();
    endtask

    task automatic run_to_idle(input string name, output int nframes);
        nframes = 0;
        while (busy && nframes < 200) begin
            frame(2, 2);
            nframes++;
        end
        if (busy) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic request(input int scr);
        req = 1'b1;
        req_screen = 2'(scr);
        step();
        req = 1'b0;
    endtask

    int nf;
    int vcnt;

    initial begin
        reset = 1'b1; v_sync = 1'b1; req = 1'b0; req_screen = '0;
        red_in = '0; green_in = '0; blue_in = '0;
        step();
        started = 1'b1;
        chk("rst_red", int'(red_out), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cur", int'(cur_screen), INIT);

        // Bypass at full brightness
        reset = 1'b0;
        red_in = 4'hA; green_in = 4'h5; blue_in = 4'hF;
        step();
        chk("byp_red", int'(red_out), 10);
        chk("byp_green", int'(green_out), 5);
        chk("byp_blue", int'(blue_out), 15);
        chk("byp_busy", int'(busy), 0);

        // Same-screen request acks immediately
        request(0);
        chk("same_ack", int'(ack), 1);
        chk("same_busy", int'(busy), 0);
        step();
        chk("same_ack_drop", int'(ack), 0);
        chk("same_red", int'(red_out), 10);

        // Full transition to screen 2
        request(2);
        chk("go_busy", int'(busy), 1);
        repeat (16) frame(3, 2);
        red_in = 4'hF;
        step();
        chk("half_red", int'(red_out), 7);
        chk("half_model", e_r, 7);
        repeat (16) frame(3, 2);
        chk("black_red", int'(red_out), 0);
        chk("black_cur", int'(cur_screen), 0);
        frame(3, 2);
        chk("swap_cur", int'(cur_screen), 2);
        repeat (31) frame(3, 2);
        chk("pre_done_busy", int'(busy), 1);
        v_sync = 1'b1;
        repeat (3) step();
        v_sync = 1'b0;
        step();
        chk("done_ack", int'(ack), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_red", int'(red_out), 14);
        step();
        chk("done_ack_drop", int'(ack), 0);
        chk("done_red_full", int'(red_out), 15);

        // Request ignored while busy
        request(1);
        repeat (5) frame(2, 2);
        request(3);
        run_to_idle("ignore", nf);
        chk("ignore_frames", nf + 5, 32 * F + 1);
        step();
        chk("ignore_cur", int'(cur_screen), 1);

        // Reset mid-fade
        request(2);
        repeat (10) frame(2, 2);
        red_in = 4'hC;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_cur", int'(cur_screen), INIT);
        chk("abort_red", int'(red_out), 0);
        chk("abort_ack", int'(ack), 0);
        step();
        chk("abort_resume", int'(red_out), 12);

        // v_sync low across reset release
        v_sync = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        request(3);
        repeat (4) step();
        run_to_idle("vslow", nf);
        chk("vslow_frames", nf, 32 * F + 1);
        chk("vslow_cur", int'(cur_screen), 3);

        // Randomized traffic
        vcnt = 3;
        for (int i = 0; i < 8000; i++) begin
            red_in = 4'($urandom); green_in = 4'($urandom); blue_in = 4'($urandom);
            req = ($urandom_range(0, 15) == 0);
            req_screen = 2'($urandom);
            reset = ($urandom_range(0, 2999) == 0);
            vcnt--;
            if (vcnt <= 0) begin
                v_sync = ~v_sync;
                vcnt = $urandom_range(1, 5);
            end
            step();
        end
        reset = 1'b0; req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/screen_fade_ctrl.md
SCREEN_FADE_CTRL -- requirements
Module: screen_fade_ctrl

Interface
REQ-001 Parameter NUM_SCREENS, default 4: number of selectable screens; screen index width SW = clog2(NUM_SCREENS).
REQ-002 Parameter FRAMES_PER_STEP, default 2: frames held at each brightness level (legal range 1..255).
REQ-003 Parameter INIT_SCREEN, default 0: screen selected after reset.
REQ-004 clk_25  in  1  pixel clock; the only clock.
REQ-005 reset  in  1  reset; synchronous, active-high.
REQ-006 v_sync  in  1  VGA vertical sync from the VGA controller, active-low.
REQ-007 req  in  1  screen-change request, sampled every cycle.
REQ-008 req_screen  in  SW  target screen index, valid with req.
REQ-009 red_in / green_in / blue_in  in  4 each  composed pixel colour levels.
REQ-010 red_out / green_out / blue_out  out  4 each  brightness-scaled colour levels.
REQ-011 cur_screen  out  SW  screen index the game logic must render.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 ack  out  1  one-cycle pulse when a request completes.

Function
REQ-014 Frame tick: register v_sync into vs_d; tick = vs_d & ~v_sync (falling edge), 1 cycle per frame.
REQ-015 Internal level register, 5 bits, range 0..16; 16 = full brightness.
REQ-016 Colour path, 1-cycle latency: x_out <= (x_in * level)[7:4]; level 16 gives x_out = x_in; level 0 gives 0.
REQ-017 FSM states: IDLE, FADE_OUT, SWAP, FADE_IN.
REQ-018 IDLE, req=1, req_screen != cur_screen: latch target, clear frame counter, go to FADE_OUT next cycle.
REQ-019 IDLE, req=1, req_screen == cur_screen: no state change; ack=1 on the next cycle.
REQ-020 req while not IDLE: ignored, no queueing; target unchanged.
REQ-021 FADE_OUT: on each tick, frame counter +1; when the counter equals FRAMES_PER_STEP-1 on a tick, clear it and decrement level by 1.
REQ-022 FADE_OUT: the tick that makes level 0 moves the FSM to SWAP.
REQ-023 SWAP: on the next tick, cur_screen <= target, clear the frame counter, go to FADE_IN; the screen is black for a full frame.
REQ-024 FADE_IN: stepping is the same as FADE_OUT, but level increments by 1.
REQ-025 FADE_IN: the tick that makes level 16 moves the FSM to IDLE, with ack=1 in the same cycle the IDLE state is entered (one cycle only).
REQ-026 Full transition takes exactly 32*FRAMES_PER_STEP + 1 ticks from acceptance to ack.
REQ-027 A req in the same cycle as the completing ack is not accepted; it is sampled only from the first IDLE cycle onward.
REQ-028 cur_screen changes only in SWAP on a tick, never mid-frame.
REQ-029 Level never underflows below 0 or exceeds 16; the counter wraps only through its clear.
REQ-030 Ticks while in IDLE have no effect.
REQ-031 busy is combinational from the state register; ack is registered.

Reset
REQ-032 Reset applies at any state, including mid-fade, and aborts the transition.
REQ-033 Values on reset: state=IDLE, level=16, frame counter=0, target=INIT_SCREEN, cur_screen=INIT_SCREEN, vs_d=1.
REQ-034 Outputs on reset: red_out/green_out/blue_out=0, ack=0, busy=0.
REQ-035 No tick is generated in the first cycle after reset when v_sync is already low.

Verification
REQ-036 Reset then red_in=0xA, green_in=0x5, blue_in=0xF in IDLE -> outputs 0xA/0x5/0xF one cycle later; cur_screen=0; busy=0.
REQ-037 FRAMES_PER_STEP=2, req with req_screen=2 -> busy=1 next cycle. After 16 ticks level=8 and red_in=0xF gives red_out=0x7. After tick 32 outputs are 0. Tick 33 sets cur_screen=2. Tick 65 gives ack=1 for one cycle, busy=0, level=16.
REQ-038 req with req_screen == cur_screen=0 -> ack=1 the next cycle; busy stays 0; outputs unscaled.
REQ-039 req with req_screen=3 during FADE_OUT of a change to 1 -> ignored; cur_screen becomes 1; one ack only.
REQ-040 Reset asserted at tick 10 of a fade -> next cycle state=IDLE, level=16, cur_screen=INIT_SCREEN, outputs 0, no ack; the bypass path resumes on the cycle after.
REQ-041 v_sync held low across reset release, then toggled -> first tick only on the following 1->0 edge.
